dmem_dma_arb: RTL and testbench
===============================

Name: dmem_dma_arb

Overview:
- Shares the single-port 256x8 data memory between the CPU load/store port and an internal block-copy (DMA) engine.
- The CPU normally has priority. The DMA engine copies `len` bytes from `src` to `dst`, one byte at a time, using free memory cycles.
- A starvation guard gives the DMA one memory cycle after a long run of CPU traffic.
- Sits between the core and the dmem instance; it drives the dmem `we`/`addr`/`di` inputs and receives the dmem `dout` output.

Parameters:
- AW, 8, address width; the DMA address counters wrap modulo 2^AW.
- DW, 8, data width.
- STARVE_LIM, 8, number of consecutive stalled DMA cycles before the DMA is forced one cycle of priority; 0 disables the guard.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU requests a memory access this cycle.
- cpu_we  in  1  CPU write (1) or read (0).
- cpu_addr  in  AW  CPU address.
- cpu_di  in  DW  CPU write data.
- cpu_gnt  out  1  CPU access performed this cycle (combinational).
- cpu_dout  out  DW  read data; equals mem_dout.
- dma_start  in  1  start-copy strobe, sampled in IDLE only.
- dma_src  in  AW  source base, sampled on an accepted start.
- dma_dst  in  AW  destination base, sampled on an accepted start.
- dma_len  in  AW  byte count, sampled on an accepted start; 0 means no transfer.
- dma_busy  out  1  high from the cycle after start acceptance until DONE is exited.
- dma_done  out  1  one-cycle completion pulse.
- mem_we  out  1  to dmem we.
- mem_addr  out  AW  to dmem addr.
- mem_di  out  DW  to dmem di.
- mem_dout  in  DW  from dmem dout (combinational read).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; src/dst/cnt/buf/starve counters = 0.
  - dma_busy=0, dma_done=0.
  - mem_we=0 and cpu_gnt=0 while in reset.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - dma_start=1 with len≠0: latch src/dst/len, go to READ.
  - dma_start=1 with len=0: go to DONE with no memory access.
- Memory ownership each cycle:
  - `dma_slot` = state∈{READ,WRITE} and (cpu_req=0 or starve_cnt==STARVE_LIM with STARVE_LIM≠0).
  - When dma_slot=1, the DMA owns the memory and cpu_gnt=0.
  - Otherwise cpu_gnt=cpu_req, and mem_addr/mem_we/mem_di come from cpu_addr/cpu_we&cpu_req/cpu_di.
  - With no requester, mem_we=0 and mem_addr=cpu_addr.
- READ with dma_slot:
  - mem_addr=src, mem_we=0.
  - buf<=mem_dout at the clock edge; go to WRITE.
- WRITE with dma_slot:
  - mem_addr=dst, mem_di=buf, mem_we=1.
  - src<=src+1, dst<=dst+1 (wrap 255→0), cnt<=cnt-1.
  - Go to DONE if cnt==1, else READ.
- READ or WRITE without dma_slot: hold all state; starve_cnt<=starve_cnt+1.
- starve_cnt clears to 0 on any dma_slot cycle and in IDLE. A forced slot lasts exactly one cycle.
- Stalled CPU: when cpu_gnt=0 with cpu_req=1, the CPU holds its request; no access is performed for it that cycle.
- DONE: dma_done=1 for exactly one cycle, dma_busy=1, then IDLE.
- dma_busy=1 in READ, WRITE and DONE.
- dma_start outside IDLE is ignored; the current copy is not restarted.
- Overlapping regions copy strictly ascending. Example: dst=src+1 replicates byte src across the region.
- Latency: an uncontended copy of N bytes takes 2N cycles in READ/WRITE plus 1 in DONE.
- CPU reads/writes have zero added latency when granted.
- Reset mid-copy aborts immediately; the memory contents already written persist.

Test Plan:
1. Reset, then CPU writes 0x5A to addr 0x10 and reads it back. Expect cpu_gnt=1 both cycles, cpu_dout=0x5A, dma_busy=0.
2. Preload 0x20..0x23 = 11,22,33,44; start src=0x20 dst=0x80 len=4 with cpu_req=0. Expect dma_done exactly 9 cycles after start; mem[0x80..0x83] = 11,22,33,44.
3. Same copy with cpu_req=1 held for 3 cycles mid-transfer (STARVE_LIM=8). Expect the DMA to stall 3 cycles, done 3 cycles later, correct data, and cpu_gnt=1 throughout.
4. Hold cpu_req=1 continuously during a copy, STARVE_LIM=8. Expect cpu_gnt=0 on exactly every 9th cycle (one forced DMA slot each time); the copy completes.
5. Start src=0xFE dst=0x00 len=3, and separately len=0. Expect source reads at 0xFE,0xFF,0x00. For len=0, expect dma_done on the cycle after start and no mem_we.
6. Assert rst_n=0 during WRITE of a len=4 copy. Expect state IDLE, dma_busy=0 and mem_we=0 immediately; a subsequent start is accepted normally.

Source files
------------

// File: rtl/dmem_dma_arb.sv
// Arbitrates the single-port data memory between the CPU load/store port and a
// byte-wise block-copy engine. The CPU wins by default, with a starvation guard for the DMA.
module dmem_dma_arb #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_LIM = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_di,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_dout,
  input  logic          dma_start,
  input  logic [AW-1:0] dma_src,
  input  logic [AW-1:0] dma_dst,
  input  logic [AW-1:0] dma_len,
  output logic          dma_busy,
  output logic          dma_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_di,
  input  logic [DW-1:0] mem_dout
);

  localparam int SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] src_reg, src_next;
  logic [AW-1:0] dst_reg, dst_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic [DW-1:0] data_reg, data_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic          copying;
  logic          forced;
  logic          dma_slot;

  assign copying  = (state_reg == READ) || (state_reg == WRITE);
  // With the guard disabled the counter may wrap freely; it is never compared.
  assign forced   = (STARVE_LIM != 0) && (starve_reg == STARVE_MAX);
  assign dma_slot = copying && (!cpu_req || forced);

  assign cpu_dout = mem_dout;
  assign dma_busy = (state_reg != IDLE);
  assign dma_done = (state_reg == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      src_reg    <= '0;
      dst_reg    <= '0;
      cnt_reg    <= '0;
      data_reg   <= '0;
      starve_reg <= '0;
    end else begin
      state_reg  <= state_next;
      src_reg    <= src_next;
      dst_reg    <= dst_next;
      cnt_reg    <= cnt_next;
      data_reg   <= data_next;
      starve_reg <= starve_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    src_next    = src_reg;
    dst_next    = dst_reg;
    cnt_next    = cnt_reg;
    data_next   = data_reg;
    starve_next = starve_reg;
    // CPU path by default; rst_n gating keeps the memory quiet while in reset.
    cpu_gnt     = rst_n && cpu_req && !dma_slot;
    mem_we      = rst_n && cpu_req && cpu_we && !dma_slot;
    mem_addr    = cpu_addr;
    mem_di      = cpu_di;

    unique case (state_reg)
      IDLE: begin
        starve_next = '0;
        if (dma_start) begin
          if (dma_len != '0) begin
            src_next   = dma_src;
            dst_next   = dma_dst;
            cnt_next   = dma_len;
            state_next = READ;
          end else begin
            state_next = DONE;
          end
        end
      end
      READ: begin
        if (dma_slot) begin
          mem_addr    = src_reg;
          mem_we      = 1'b0;
          data_next   = mem_dout;
          starve_next = '0;
          state_next  = WRITE;
        end else begin
          starve_next = starve_reg + SW'(1);
        end
      end
      WRITE: begin
        if (dma_slot) begin
          mem_addr    = dst_reg;
          mem_di      = data_reg;
          mem_we      = 1'b1;
          src_next    = src_reg + AW'(1);
          dst_next    = dst_reg + AW'(1);
          cnt_next    = cnt_reg - AW'(1);
          starve_next = '0;
          state_next  = (cnt_reg == AW'(1)) ? DONE : READ;
        end else begin
          starve_next = starve_reg + SW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_dma_arb.sv
// Directed bench for dmem_dma_arb with a behavioural 256x8 dmem (combinational read).
module tb_dmem_dma_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_di = '0;
  logic       cpu_gnt;
  logic [7:0] cpu_dout;
  logic       dma_start = 1'b0;
  logic [7:0] dma_src = '0, dma_dst = '0, dma_len = '0;
  logic       dma_busy, dma_done;
  logic       mem_we;
  logic [7:0] mem_addr, mem_di, mem_dout;

  logic [7:0] mem [256];

  int n_vec = 0;
  int n_err = 0;
  int done_cyc;
  logic [7:0] t5_addr [6];
  logic       t5_we   [6];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_di;
  assign mem_dout = mem[mem_addr];

  dmem_dma_arb #(.AW(8), .DW(8), .STARVE_LIM(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
    .cpu_gnt(cpu_gnt), .cpu_dout(cpu_dout),
    .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_dout(mem_dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_di = d;
    next_cyc();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic start_dma(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    dma_start = 1'b1; dma_src = s; dma_dst = d; dma_len = n;
    next_cyc();
    dma_start = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after the start edge) of dma_done, 0 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 200 && cyc == 0; c++) begin
      @(negedge clk);
      if (dma_done) cyc = c;
      next_cyc();
    end
  endtask

  initial begin
    t5_addr = '{8'hFE, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h02};
    t5_we   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset: outputs quiet even with requests pending
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h33; dma_start = 1'b1; dma_len = 8'h04;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(dma_busy), 32'd0);
    check("rst_done", 32'(dma_done), 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0; dma_start = 1'b0; dma_len = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    next_cyc();

    // 1: CPU write then read back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_di = 8'h5A;
    @(negedge clk);
    check("t1_wr_gnt", 32'(cpu_gnt), 32'd1);
    check("t1_wr_we", 32'(mem_we), 32'd1);
    next_cyc();
    cpu_we = 1'b0;
    @(negedge clk);
    check("t1_rd_gnt", 32'(cpu_gnt), 32'd1);
    check("t1_rd_data", 32'(cpu_dout), 32'h5A);
    check("t1_busy", 32'(dma_busy), 32'd0);
    next_cyc();
    cpu_req = 1'b0;

    // 2: uncontended 4-byte copy
    cpu_write(8'h20, 8'h11); cpu_write(8'h21, 8'h22);
    cpu_write(8'h22, 8'h33); cpu_write(8'h23, 8'h44);
    start_dma(8'h20, 8'h80, 8'd4);
    check("t2_busy", 32'(dma_busy), 32'd1);
    wait_done(done_cyc);
    check("t2_done_cyc", 32'(done_cyc), 32'd9);
    check("t2_busy_after", 32'(dma_busy), 32'd0);
    for (int i = 0; i < 4; i++)
      check("t2_mem", 32'(mem[8'h80 + i]), 32'(8'h11 * (i + 1)));

    // 3: CPU holds the port for 3 cycles mid-copy
    start_dma(8'h20, 8'h90, 8'd4);
    done_cyc = 0;
    for (int c = 1; c <= 200 && done_cyc == 0; c++) begin
      cpu_req = (c >= 3 && c <= 5); cpu_we = 1'b0; cpu_addr = 8'h20;
      @(negedge clk);
      if (cpu_req) check("t3_gnt", 32'(cpu_gnt), 32'd1);
      if (dma_done) done_cyc = c;
      next_cyc();
    end
    cpu_req = 1'b0;
    check("t3_done_cyc", 32'(done_cyc), 32'd12);
    for (int i = 0; i < 4; i++)
      check("t3_mem", 32'(mem[8'h90 + i]), 32'(8'h11 * (i + 1)));

    // 4: continuous CPU traffic; the guard hands the DMA every 9th cycle
    start_dma(8'h20, 8'hA0, 8'd4);
    done_cyc = 0;
    for (int c = 1; c <= 200 && done_cyc == 0; c++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00;
      @(negedge clk);
      check("t4_gnt", 32'(cpu_gnt), 32'((c % 9) != 0));
      if (dma_done) done_cyc = c;
      next_cyc();
    end
    cpu_req = 1'b0;
    check("t4_done_cyc", 32'(done_cyc), 32'd73);
    for (int i = 0; i < 4; i++)
      check("t4_mem", 32'(mem[8'hA0 + i]), 32'(8'h11 * (i + 1)));

    // 5a: source wraps past 0xFF; the third read sees the byte just written to 0x00
    cpu_write(8'hFE, 8'hA1); cpu_write(8'hFF, 8'hB2); cpu_write(8'h00, 8'hC3);
    start_dma(8'hFE, 8'h00, 8'd3);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t5_addr", 32'(mem_addr), 32'(t5_addr[c]));
      check("t5_we", 32'(mem_we), 32'(t5_we[c]));
      next_cyc();
    end
    @(negedge clk);
    check("t5_done", 32'(dma_done), 32'd1);
    next_cyc();
    check("t5_mem0", 32'(mem[8'h00]), 32'hA1);
    check("t5_mem1", 32'(mem[8'h01]), 32'hB2);
    check("t5_mem2", 32'(mem[8'h02]), 32'hA1);

    // 5b: zero-length copy
    start_dma(8'h20, 8'h50, 8'd0);
    @(negedge clk);
    check("t5b_done", 32'(dma_done), 32'd1);
    check("t5b_busy", 32'(dma_busy), 32'd1);
    check("t5b_we", 32'(mem_we), 32'd0);
    next_cyc();
    check("t5b_idle", 32'(dma_busy), 32'd0);

    // 6: reset during the second WRITE; first byte persists
    cpu_write(8'hC0, 8'h00); cpu_write(8'hC1, 8'h00);
    start_dma(8'h20, 8'hC0, 8'd4);
    repeat (3) next_cyc();
    @(negedge clk);
    check("t6_wr_we", 32'(mem_we), 32'd1);
    check("t6_wr_addr", 32'(mem_addr), 32'hC1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(dma_busy), 32'd0);
    check("t6_rst_we", 32'(mem_we), 32'd0);
    check("t6_rst_done", 32'(dma_done), 32'd0);
    @(posedge clk); #1;
    check("t6_mem0", 32'(mem[8'hC0]), 32'h11);
    check("t6_mem1", 32'(mem[8'hC1]), 32'h00);
    rst_n = 1'b1;
    next_cyc();
    start_dma(8'h20, 8'hC0, 8'd4);
    wait_done(done_cyc);
    check("t6_done_cyc", 32'(done_cyc), 32'd9);
    for (int i = 0; i < 4; i++)
      check("t6_mem", 32'(mem[8'hC0 + i]), 32'(8'h11 * (i + 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
